// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix-multiply datapath: lane count and write-stage FSM states.
package matrix_pkg;

  localparam int unsigned DATA_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/line_assembler.sv
// Packs results lane by lane into a line and hands closed lines to a one-entry pending buffer.
module line_assembler
  import matrix_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = DATA_SIZE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          push_row_end,
  input  logic                          take,
  output logic                          pend_valid,
  output logic [LANES*DATA_WIDTH-1:0]   pend_data,
  output logic                          pend_now,
  output logic                          stall_next_c,
  output logic                          empty_c
);

  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] line_t;

  logic [LANE_W-1:0] lane_q, lane_d;
  line_t             asm_q, asm_d;
  logic              closed_q, closed_d;
  logic              held_now_q, held_now_d;
  logic              pv_q, pv_d;
  line_t             pdata_q, pdata_d;
  logic              pnow_q, pnow_d;

  line_t             base_line;
  line_t             ins;
  logic              pend_free;

  always_comb begin
    lane_d     = lane_q;
    asm_d      = asm_q;
    closed_d   = closed_q;
    held_now_d = held_now_q;
    pv_d       = pv_q;
    pdata_d    = pdata_q;
    pnow_d     = pnow_q;
    base_line  = asm_q;
    ins        = asm_q;
    pend_free  = !pv_q;

    if (take) begin
      pv_d = 1'b0;
    end

    // A line held closed in assembly moves over as soon as pending is empty.
    if (closed_q && !pv_q) begin
      pv_d      = 1'b1;
      pdata_d   = asm_q;
      pnow_d    = held_now_q;
      closed_d  = 1'b0;
      asm_d     = '0;
      base_line = '0;
      pend_free = 1'b0;
    end

    if (push) begin
      ins         = base_line;
      ins[lane_q] = push_data;
      if ((lane_q == LAST_LANE) || push_row_end) begin
        lane_d = '0;
        if (pend_free) begin
          pv_d    = 1'b1;
          pdata_d = ins;
          pnow_d  = push_row_end;
          asm_d   = '0;
        end else begin
          closed_d   = 1'b1;
          asm_d      = ins;
          held_now_d = push_row_end;
        end
      end else begin
        lane_d = lane_q + LANE_W'(1);
        asm_d  = ins;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q     <= '0;
      asm_q      <= '0;
      closed_q   <= 1'b0;
      held_now_q <= 1'b0;
      pv_q       <= 1'b0;
      pdata_q    <= '0;
      pnow_q     <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      asm_q      <= asm_d;
      closed_q   <= closed_d;
      held_now_q <= held_now_d;
      pv_q       <= pv_d;
      pdata_q    <= pdata_d;
      pnow_q     <= pnow_d;
    end
  end

  assign pend_valid   = pv_q;
  assign pend_data    = pdata_q;
  assign pend_now     = pnow_q;
  assign stall_next_c = closed_d && pv_d;
  assign empty_c      = (lane_q == '0) && !closed_q && !pv_q;

endmodule

// File: rtl/result_line_packer.sv
// Write stage: packs dot-product results into cache lines, issues CCI writes, counts completions.
module result_line_packer
  import matrix_pkg::*;
#(
  parameter int unsigned ADDR_LMT    = 20,
  parameter int unsigned MDATA       = 14,
  parameter int unsigned CACHE_WIDTH = 512,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  input  logic [ADDR_LMT+3:0]     cfg_base,
  input  logic [ADDR_LMT-1:0]     cfg_row_len,
  input  logic [ADDR_LMT-1:0]     cfg_rows,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  output logic [ADDR_LMT+3:0]     wr_req_addr,
  output logic [MDATA-1:0]        wr_req_mdata,
  output logic [CACHE_WIDTH-1:0]  wr_req_data,
  output logic                    wr_req_en,
  output logic                    wr_req_now,
  output logic                    wr_req_direct,
  input  logic                    wr_req_almostfull,
  input  logic                    wr_rsp_valid,
  input  logic                    wr_rsp_rvalid,
  output logic                    done
);

  localparam int unsigned AW        = ADDR_LMT + 4;
  localparam int unsigned RLW       = ADDR_LMT + 1;
  localparam int unsigned PW        = ADDR_LMT + RLW;
  localparam int unsigned LANES     = CACHE_WIDTH / DATA_WIDTH;
  localparam int unsigned LANE_BITS = $clog2(LANES);

  state_e                 state_q, state_d;
  logic [AW-1:0]          base_q, base_d;
  logic [ADDR_LMT-1:0]    row_len_q, row_len_d;
  logic [ADDR_LMT-1:0]    rows_q, rows_d;
  logic [AW-1:0]          total_q, total_d;
  logic [ADDR_LMT-1:0]    col_q, col_d;
  logic [ADDR_LMT-1:0]    row_q, row_d;
  logic [AW-1:0]          line_cnt_q, line_cnt_d;
  logic [AW-1:0]          rsp_cnt_q, rsp_cnt_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [MDATA-1:0]       mdata_q, mdata_d;
  logic [CACHE_WIDTH-1:0] data_q, data_d;
  logic                   en_q, en_d;
  logic                   now_q, now_d;
  logic                   in_ready_q, in_ready_d;
  logic                   done_q, done_d;

  logic [RLW-1:0]         lpr_c;
  logic [PW-1:0]          prod_c;
  logic                   push_c;
  logic                   row_end_c;
  logic                   issue_c;
  logic                   pend_valid;
  logic [CACHE_WIDTH-1:0] pend_data;
  logic                   pend_now;
  logic                   stall_next_c;
  logic                   asm_empty_c;

  assign lpr_c     = (RLW'(cfg_row_len) + RLW'(LANES - 1)) >> LANE_BITS;
  assign prod_c    = PW'(cfg_rows) * PW'(lpr_c);
  assign push_c    = in_valid && in_ready_q;
  assign row_end_c = (col_q == (row_len_q - ADDR_LMT'(1)));
  assign issue_c   = pend_valid && !wr_req_almostfull;

  line_assembler #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_asm (
    .clk          (clk),
    .rst          (rst),
    .push         (push_c),
    .push_data    (in_data),
    .push_row_end (row_end_c),
    .take         (issue_c),
    .pend_valid   (pend_valid),
    .pend_data    (pend_data),
    .pend_now     (pend_now),
    .stall_next_c (stall_next_c),
    .empty_c      (asm_empty_c)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    row_len_d  = row_len_q;
    rows_d     = rows_q;
    total_d    = total_q;
    col_d      = col_q;
    row_d      = row_q;
    line_cnt_d = line_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;
    addr_d     = addr_q;
    mdata_d    = mdata_q;
    data_d     = data_q;
    now_d      = now_q;
    en_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          base_d     = cfg_base;
          row_len_d  = cfg_row_len;
          rows_d     = cfg_rows;
          total_d    = AW'(prod_c);
          col_d      = '0;
          row_d      = '0;
          line_cnt_d = '0;
          rsp_cnt_d  = '0;
          state_d    = ((cfg_row_len == '0) || (cfg_rows == '0)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (push_c) begin
          if (row_end_c) begin
            col_d = '0;
            row_d = row_q + ADDR_LMT'(1);
            if (row_q == (rows_q - ADDR_LMT'(1))) begin
              state_d = DRAIN;
            end
          end else begin
            col_d = col_q + ADDR_LMT'(1);
          end
        end
      end
      DRAIN: begin
        if (asm_empty_c && (rsp_cnt_q == total_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Each of valid/rvalid is a separate completion.
    if ((state_q == RUN) || (state_q == DRAIN)) begin
      rsp_cnt_d = rsp_cnt_q + AW'(wr_rsp_valid) + AW'(wr_rsp_rvalid);
    end

    if (issue_c) begin
      en_d       = 1'b1;
      addr_d     = base_q + line_cnt_q;
      data_d     = pend_data;
      now_d      = pend_now;
      mdata_d    = MDATA'(line_cnt_q);
      line_cnt_d = line_cnt_q + AW'(1);
    end
  end

  assign in_ready_d = (state_d == RUN) && !stall_next_c;
  assign done_d     = (state_d == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      row_len_q  <= '0;
      rows_q     <= '0;
      total_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      line_cnt_q <= '0;
      rsp_cnt_q  <= '0;
      addr_q     <= '0;
      mdata_q    <= '0;
      data_q     <= '0;
      en_q       <= 1'b0;
      now_q      <= 1'b0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      row_len_q  <= row_len_d;
      rows_q     <= rows_d;
      total_q    <= total_d;
      col_q      <= col_d;
      row_q      <= row_d;
      line_cnt_q <= line_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      addr_q     <= addr_d;
      mdata_q    <= mdata_d;
      data_q     <= data_d;
      en_q       <= en_d;
      now_q      <= now_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign wr_req_addr   = addr_q;
  assign wr_req_mdata  = mdata_q;
  assign wr_req_data   = data_q;
  assign wr_req_en     = en_q;
  assign wr_req_now    = now_q;
  assign wr_req_direct = 1'b0;
  assign done          = done_q;

endmodule
